// File: rtl/axil_periph_decoder.sv
// axil_periph_decoder: AXI4-Lite 1-to-NUM_SLV address decoder.
// One write and one read in flight at a time, on independent FSMs.
// Lowest-index matching window wins; the decode is registered when the address is captured.
// Optional macro AXIL_DEC_DECERR_EN: unmatched addresses are answered locally with DECERR.
// Without it, unmatched addresses go to port NUM_SLV-1 (the default slave).
module axil_periph_decoder #(
    parameter int NUM_SLV        = 2,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter logic [NUM_SLV*AXI_ADDR_WIDTH-1:0] SLV_BASE = {32'h1000_0000, 32'h0200_0000},
    parameter logic [NUM_SLV*AXI_ADDR_WIDTH-1:0] SLV_MASK = {32'hFFFF_0000, 32'hFFFF_0000}
) (
    input  logic                                  s_axi_aclk,
    input  logic                                  s_axi_aresetn,
    // upstream write address / data / response
    input  logic [AXI_ADDR_WIDTH-1:0]             s_axi_awaddr,
    input  logic [2:0]                            s_axi_awprot,
    input  logic                                  s_axi_awvalid,
    output logic                                  s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]             s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]           s_axi_wstrb,
    input  logic                                  s_axi_wvalid,
    output logic                                  s_axi_wready,
    output logic [1:0]                            s_axi_bresp,
    output logic                                  s_axi_bvalid,
    input  logic                                  s_axi_bready,
    // upstream read address / data
    input  logic [AXI_ADDR_WIDTH-1:0]             s_axi_araddr,
    input  logic [2:0]                            s_axi_arprot,
    input  logic                                  s_axi_arvalid,
    output logic                                  s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]             s_axi_rdata,
    output logic [1:0]                            s_axi_rresp,
    output logic                                  s_axi_rvalid,
    input  logic                                  s_axi_rready,
    // downstream per-port channels
    output logic [NUM_SLV*AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [NUM_SLV*3-1:0]                  m_axi_awprot,
    output logic [NUM_SLV-1:0]                    m_axi_awvalid,
    input  logic [NUM_SLV-1:0]                    m_axi_awready,
    output logic [NUM_SLV*AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [NUM_SLV*AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic [NUM_SLV-1:0]                    m_axi_wvalid,
    input  logic [NUM_SLV-1:0]                    m_axi_wready,
    input  logic [NUM_SLV*2-1:0]                  m_axi_bresp,
    input  logic [NUM_SLV-1:0]                    m_axi_bvalid,
    output logic [NUM_SLV-1:0]                    m_axi_bready,
    output logic [NUM_SLV*AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [NUM_SLV*3-1:0]                  m_axi_arprot,
    output logic [NUM_SLV-1:0]                    m_axi_arvalid,
    input  logic [NUM_SLV-1:0]                    m_axi_arready,
    input  logic [NUM_SLV*AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [NUM_SLV*2-1:0]                  m_axi_rresp,
    input  logic [NUM_SLV-1:0]                    m_axi_rvalid,
    output logic [NUM_SLV-1:0]                    m_axi_rready
);

    localparam int AW  = AXI_ADDR_WIDTH;
    localparam int DW  = AXI_DATA_WIDTH;
    localparam int STW = DW / 8;
    localparam int SW  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

`ifdef AXIL_DEC_DECERR_EN
    localparam bit DECERR_EN = 1'b1;
`else
    localparam bit DECERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [SW-1:0] sel;
        logic          loc;   // answer locally with DECERR
    } dec_t;

    typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_BACK} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FWD, R_WAIT, R_BACK} r_state_t;

    // Scan downward so the lowest matching index is the one left standing.
    function automatic dec_t decode(input logic [AW-1:0] a);
        dec_t d;
        logic hit;
        hit   = 1'b0;
        d.sel = SW'(NUM_SLV - 1);
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((a & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                d.sel = SW'(i);
                hit   = 1'b1;
            end
        end
        d.loc = DECERR_EN & ~hit;
        return d;
    endfunction

    function automatic logic [NUM_SLV-1:0] onehot(input logic [SW-1:0] s);
        logic [NUM_SLV-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    // write path state
    w_state_t           w_state;
    logic               aw_held, w_held;
    logic [AW-1:0]      aw_addr_q;
    logic [2:0]         aw_prot_q;
    logic [DW-1:0]      wdata_q;
    logic [STW-1:0]     wstrb_q;
    logic [SW-1:0]      w_sel;
    logic               w_loc;
    logic               awready_q, wready_q, bvalid_q;
    logic [1:0]         bresp_q;
    logic [NUM_SLV-1:0] m_awvalid_q, m_wvalid_q, m_bready_q;

    // read path state
    r_state_t           r_state;
    logic [AW-1:0]      ar_addr_q;
    logic [2:0]         ar_prot_q;
    logic [SW-1:0]      r_sel;
    logic               arready_q, rvalid_q;
    logic [DW-1:0]      rdata_q;
    logic [1:0]         rresp_q;
    logic [NUM_SLV-1:0] m_arvalid_q, m_rready_q;

    dec_t          wdec, rdec;
    logic          aw_now, w_now, go_loc, aw_done, w_done;
    logic [SW-1:0] go_sel;

    assign wdec    = decode(s_axi_awaddr);
    assign rdec    = decode(s_axi_araddr);
    // A beat counts as held once captured, or when it is being captured this cycle.
    assign aw_now  = aw_held | (s_axi_awvalid & awready_q);
    assign w_now   = w_held  | (s_axi_wvalid  & wready_q);
    assign go_sel  = aw_held ? w_sel : wdec.sel;
    assign go_loc  = aw_held ? w_loc : wdec.loc;
    assign aw_done = ~m_awvalid_q[w_sel] | m_axi_awready[w_sel];
    assign w_done  = ~m_wvalid_q[w_sel]  | m_axi_wready[w_sel];

    // Write FSM: collect AW and W in any order, forward, relay B.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state     <= W_IDLE;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_addr_q   <= '0;
            aw_prot_q   <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            w_sel       <= '0;
            w_loc       <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            m_awvalid_q <= '0;
            m_wvalid_q  <= '0;
            m_bready_q  <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s_axi_awvalid && awready_q) begin
                        aw_addr_q <= s_axi_awaddr;
                        aw_prot_q <= s_axi_awprot;
                        w_sel     <= wdec.sel;
                        w_loc     <= wdec.loc;
                        aw_held   <= 1'b1;
                        awready_q <= 1'b0;
                    end else if (!aw_held) begin
                        awready_q <= 1'b1;
                    end
                    if (s_axi_wvalid && wready_q) begin
                        wdata_q  <= s_axi_wdata;
                        wstrb_q  <= s_axi_wstrb;
                        w_held   <= 1'b1;
                        wready_q <= 1'b0;
                    end else if (!w_held) begin
                        wready_q <= 1'b1;
                    end
                    if (aw_now && w_now) begin
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        if (go_loc) begin
                            bresp_q  <= 2'b11;
                            bvalid_q <= 1'b1;
                            w_state  <= W_BACK;
                        end else begin
                            m_awvalid_q <= onehot(go_sel);
                            m_wvalid_q  <= onehot(go_sel);
                            w_state     <= W_FWD;
                        end
                    end
                end
                W_FWD: begin
                    if (m_axi_awready[w_sel]) m_awvalid_q <= '0;
                    if (m_axi_wready[w_sel])  m_wvalid_q  <= '0;
                    if (aw_done && w_done) begin
                        m_bready_q <= onehot(w_sel);
                        w_state    <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (m_axi_bvalid[w_sel]) begin
                        bresp_q    <= m_axi_bresp[int'(w_sel)*2 +: 2];
                        m_bready_q <= '0;
                        bvalid_q   <= 1'b1;
                        w_state    <= W_BACK;
                    end
                end
                W_BACK: begin
                    if (s_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: capture AR, forward, relay R (or answer locally).
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state     <= R_IDLE;
            ar_addr_q   <= '0;
            ar_prot_q   <= '0;
            r_sel       <= '0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= 2'b00;
            m_arvalid_q <= '0;
            m_rready_q  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axi_arvalid && arready_q) begin
                        ar_addr_q <= s_axi_araddr;
                        ar_prot_q <= s_axi_arprot;
                        r_sel     <= rdec.sel;
                        arready_q <= 1'b0;
                        if (rdec.loc) begin
                            rdata_q  <= '0;
                            rresp_q  <= 2'b11;
                            rvalid_q <= 1'b1;
                            r_state  <= R_BACK;
                        end else begin
                            m_arvalid_q <= onehot(rdec.sel);
                            r_state     <= R_FWD;
                        end
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_FWD: begin
                    if (m_axi_arready[r_sel]) begin
                        m_arvalid_q <= '0;
                        m_rready_q  <= onehot(r_sel);
                        r_state     <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (m_axi_rvalid[r_sel]) begin
                        rdata_q    <= m_axi_rdata[int'(r_sel)*DW +: DW];
                        rresp_q    <= m_axi_rresp[int'(r_sel)*2 +: 2];
                        m_rready_q <= '0;
                        rvalid_q   <= 1'b1;
                        r_state    <= R_BACK;
                    end
                end
                R_BACK: begin
                    if (s_axi_rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Payload is broadcast to every port; only the selected port sees a valid.
    assign m_axi_awaddr  = {NUM_SLV{aw_addr_q}};
    assign m_axi_awprot  = {NUM_SLV{aw_prot_q}};
    assign m_axi_wdata   = {NUM_SLV{wdata_q}};
    assign m_axi_wstrb   = {NUM_SLV{wstrb_q}};
    assign m_axi_araddr  = {NUM_SLV{ar_addr_q}};
    assign m_axi_arprot  = {NUM_SLV{ar_prot_q}};
    assign m_axi_awvalid = m_awvalid_q;
    assign m_axi_wvalid  = m_wvalid_q;
    assign m_axi_bready  = m_bready_q;
    assign m_axi_arvalid = m_arvalid_q;
    assign m_axi_rready  = m_rready_q;

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axil_periph_decoder.sv
// tb_axil_periph_decoder: directed bench for axil_periph_decoder with slave
// models per port and a per-cycle compare process against an address-map model.
module tb_axil_periph_decoder;
    localparam int NS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] s_axi_awaddr = '0;  logic [2:0] s_axi_awprot = '0;
    logic s_axi_awvalid = 1'b0, s_axi_awready;
    logic [31:0] s_axi_wdata = '0;   logic [3:0] s_axi_wstrb = '0;
    logic s_axi_wvalid = 1'b0, s_axi_wready;
    logic [1:0] s_axi_bresp;  logic s_axi_bvalid, s_axi_bready = 1'b0;
    logic [31:0] s_axi_araddr = '0;  logic [2:0] s_axi_arprot = '0;
    logic s_axi_arvalid = 1'b0, s_axi_arready;
    logic [31:0] s_axi_rdata; logic [1:0] s_axi_rresp;
    logic s_axi_rvalid, s_axi_rready = 1'b0;

    logic [NS*32-1:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [NS*3-1:0]  m_axi_awprot, m_axi_arprot;
    logic [NS*4-1:0]  m_axi_wstrb;
    logic [NS*2-1:0]  m_axi_bresp, m_axi_rresp;
    logic [NS-1:0] m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [NS-1:0] m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic [NS-1:0] m_axi_rvalid, m_axi_rready;

    axil_periph_decoder dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- address-map model ----------------
    logic [31:0] base_t[NS] = '{32'h0200_0000, 32'h1000_0000};
    logic [31:0] mask_t[NS] = '{32'hFFFF_0000, 32'hFFFF_0000};

    // -1 means "answered locally"
    function automatic int exp_port(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & mask_t[i]) == base_t[i]) return i;
`ifdef AXIL_DEC_DECERR_EN
        return -1;
`else
        return NS - 1;
`endif
    endfunction

    function automatic int sum(input int v[NS]);
        int s = 0;
        for (int i = 0; i < NS; i++) s += v[i];
        return s;
    endfunction

    // current expected routing; -2 = nothing in flight, no downstream activity allowed
    int wr_port = -2, rd_port = -2;
    logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
    logic [3:0]  wr_strb = '0;

    // ---------------- slave models ----------------
    int aw_stall[NS], b_dly[NS], r_dly[NS];
    logic [1:0] bresp_cfg[NS], rresp_cfg[NS];
    logic [31:0] rdata_cfg[NS];
    int aw_hs[NS], w_hs[NS], ar_hs[NS], b_hs[NS], r_hs[NS];
    int awwait[NS], bwait[NS], rwait[NS];
    logic [NS-1:0] got_aw, got_w, bpend, rpend;
    logic [NS-1:0] hs_aw, hs_w, hs_b, hs_ar, hs_r;

    initial begin
        m_axi_awready = '0; m_axi_wready = '0; m_axi_bvalid = '0; m_axi_bresp = '0;
        m_axi_arready = '0; m_axi_rvalid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
        got_aw = '0; got_w = '0; bpend = '0; rpend = '0;
        hs_aw = '0; hs_w = '0; hs_b = '0; hs_ar = '0; hs_r = '0;
        for (int p = 0; p < NS; p++) begin
            aw_hs[p] = 0; w_hs[p] = 0; ar_hs[p] = 0; b_hs[p] = 0; r_hs[p] = 0;
            awwait[p] = 0; bwait[p] = 0; rwait[p] = 0;
        end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_axi_awready = '0; m_axi_wready = '0; m_axi_bvalid = '0;
                m_axi_arready = '0; m_axi_rvalid = '0;
                got_aw = '0; got_w = '0; bpend = '0; rpend = '0;
                hs_aw = '0; hs_w = '0; hs_b = '0; hs_ar = '0; hs_r = '0;
                for (int p = 0; p < NS; p++) begin awwait[p] = 0; bwait[p] = 0; rwait[p] = 0; end
            end else begin
                // decide readies/valids for the coming edge
                for (int p = 0; p < NS; p++) begin
                    if (m_axi_awvalid[p] && !m_axi_awready[p]) begin
                        if (awwait[p] >= aw_stall[p]) m_axi_awready[p] = 1'b1;
                        else awwait[p]++;
                    end
                    if (m_axi_wvalid[p]) m_axi_wready[p] = 1'b1;
                    if (m_axi_arvalid[p]) m_axi_arready[p] = 1'b1;
                    if (bpend[p] && !m_axi_bvalid[p]) begin
                        if (bwait[p] >= b_dly[p]) begin
                            m_axi_bvalid[p] = 1'b1; m_axi_bresp[p*2 +: 2] = bresp_cfg[p]; bpend[p] = 1'b0;
                        end else bwait[p]++;
                    end
                    if (rpend[p] && !m_axi_rvalid[p]) begin
                        if (rwait[p] >= r_dly[p]) begin
                            m_axi_rvalid[p] = 1'b1; m_axi_rdata[p*32 +: 32] = rdata_cfg[p];
                            m_axi_rresp[p*2 +: 2] = rresp_cfg[p]; rpend[p] = 1'b0;
                        end else rwait[p]++;
                    end
                    hs_aw[p] = m_axi_awvalid[p] & m_axi_awready[p];
                    hs_w[p]  = m_axi_wvalid[p]  & m_axi_wready[p];
                    hs_ar[p] = m_axi_arvalid[p] & m_axi_arready[p];
                    hs_b[p]  = m_axi_bvalid[p]  & m_axi_bready[p];
                    hs_r[p]  = m_axi_rvalid[p]  & m_axi_rready[p];
                end
                @(posedge clk);
                #1;
                if (rst_n) begin
                    for (int p = 0; p < NS; p++) begin
                        if (hs_aw[p]) begin m_axi_awready[p] = 1'b0; aw_hs[p]++; got_aw[p] = 1'b1; awwait[p] = 0; end
                        if (hs_w[p])  begin m_axi_wready[p] = 1'b0;  w_hs[p]++;  got_w[p] = 1'b1; end
                        if (got_aw[p] && got_w[p]) begin
                            got_aw[p] = 1'b0; got_w[p] = 1'b0; bpend[p] = 1'b1; bwait[p] = 0;
                        end
                        if (hs_b[p])  begin m_axi_bvalid[p] = 1'b0; b_hs[p]++; end
                        if (hs_ar[p]) begin m_axi_arready[p] = 1'b0; ar_hs[p]++; rpend[p] = 1'b1; rwait[p] = 0; end
                        if (hs_r[p])  begin m_axi_rvalid[p] = 1'b0; r_hs[p]++; end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic pbv = 1'b0, pbr = 1'b0, prv = 1'b0, prr = 1'b0;
    logic [1:0] pbresp = '0, prresp = '0;
    logic [31:0] prdata = '0;
    int awv_cyc[NS], wv_cyc[NS];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs",
                {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
                 s_axi_bresp, s_axi_rresp, s_axi_rdata, m_axi_awvalid, m_axi_wvalid,
                 m_axi_bready, m_axi_arvalid, m_axi_rready}, 64'd0);
            pbv = 1'b0; prv = 1'b0;
        end else begin
            for (int p = 0; p < NS; p++) begin
                if (m_axi_awvalid[p]) begin
                    awv_cyc[p]++;
                    chk("awvalid_port", p, wr_port);
                    chk("awaddr", m_axi_awaddr[p*32 +: 32], wr_addr);
                end
                if (m_axi_wvalid[p]) begin
                    wv_cyc[p]++;
                    chk("wvalid_port", p, wr_port);
                    chk("wdata_wstrb", {m_axi_wdata[p*32 +: 32], m_axi_wstrb[p*4 +: 4]}, {wr_data, wr_strb});
                end
                if (m_axi_bready[p]) chk("bready_port", p, wr_port);
                if (m_axi_arvalid[p]) begin
                    chk("arvalid_port", p, rd_port);
                    chk("araddr", m_axi_araddr[p*32 +: 32], rd_addr);
                end
                if (m_axi_rready[p]) chk("rready_port", p, rd_port);
            end
            if (pbv && !pbr) begin
                chk("bvalid_hold", s_axi_bvalid, 1);
                chk("bresp_stable", s_axi_bresp, pbresp);
            end
            if (prv && !prr) begin
                chk("rvalid_hold", s_axi_rvalid, 1);
                chk("rpayload_stable", {s_axi_rresp, s_axi_rdata}, {prresp, prdata});
            end
            pbv = s_axi_bvalid; pbr = s_axi_bready; pbresp = s_axi_bresp;
            prv = s_axi_rvalid; prr = s_axi_rready; prresp = s_axi_rresp; prdata = s_axi_rdata;
        end
    end

    // ---------------- upstream drivers ----------------
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input int aw_dly, input int w_dly, input int b_hold,
                            output logic [1:0] br);
        int port, t, aw0, b0;
        logic [1:0] expb;
        port = exp_port(a);
        expb = (port < 0) ? 2'b11 : bresp_cfg[port];
        aw0 = sum(aw_hs); b0 = sum(b_hs);
        wr_addr = a; wr_data = d; wr_strb = 4'hF; wr_port = port;
        fork
            begin : aw_branch
                int n;
                repeat (aw_dly + 1) @(posedge clk);
                #1 s_axi_awaddr = a; s_axi_awprot = 3'b000; s_axi_awvalid = 1'b1;
                n = 0;
                do begin @(negedge clk); n++; end while (!s_axi_awready && n < 50);
                chk("aw_accept", s_axi_awready, 1);
                @(posedge clk); #1 s_axi_awvalid = 1'b0;
            end
            begin : w_branch
                int n;
                repeat (w_dly + 1) @(posedge clk);
                #1 s_axi_wdata = d; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
                n = 0;
                do begin @(negedge clk); n++; end while (!s_axi_wready && n < 50);
                chk("w_accept", s_axi_wready, 1);
                @(posedge clk); #1 s_axi_wvalid = 1'b0;
            end
        join
        t = 0;
        while (!s_axi_bvalid && t < 100) begin @(negedge clk); t++; end
        chk("b_arrive", s_axi_bvalid, 1);
        repeat (b_hold) @(negedge clk);
        @(posedge clk); #1 s_axi_bready = 1'b1;
        @(negedge clk);
        br = s_axi_bresp;
        chk("bvalid_at_hs", s_axi_bvalid, 1);
        chk("bresp", s_axi_bresp, expb);
        @(posedge clk); #1 s_axi_bready = 1'b0;
        @(negedge clk);
        chk("b_single", s_axi_bvalid, 0);
        chk("aw_fwd_count", sum(aw_hs) - aw0, (port < 0) ? 0 : 1);
        chk("b_fwd_count", sum(b_hs) - b0, (port < 0) ? 0 : 1);
        wr_port = -2;
    endtask

    task automatic do_read(input logic [31:0] a, input int r_hold,
                           output logic [31:0] rd, output logic [1:0] rr);
        int port, t, ar0;
        logic [31:0] expd;
        logic [1:0] expr;
        port = exp_port(a);
        expd = (port < 0) ? 32'h0 : rdata_cfg[port];
        expr = (port < 0) ? 2'b11 : rresp_cfg[port];
        ar0 = sum(ar_hs);
        rd_addr = a; rd_port = port;
        @(posedge clk);
        #1 s_axi_araddr = a; s_axi_arprot = 3'b000; s_axi_arvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!s_axi_arready && t < 50);
        chk("ar_accept", s_axi_arready, 1);
        @(posedge clk); #1 s_axi_arvalid = 1'b0;
        t = 0;
        while (!s_axi_rvalid && t < 100) begin @(negedge clk); t++; end
        chk("r_arrive", s_axi_rvalid, 1);
        repeat (r_hold) @(negedge clk);
        @(posedge clk); #1 s_axi_rready = 1'b1;
        @(negedge clk);
        rd = s_axi_rdata; rr = s_axi_rresp;
        chk("rvalid_at_hs", s_axi_rvalid, 1);
        chk("rdata", s_axi_rdata, expd);
        chk("rresp", s_axi_rresp, expr);
        @(posedge clk); #1 s_axi_rready = 1'b0;
        @(negedge clk);
        chk("r_single", s_axi_rvalid, 0);
        chk("ar_fwd_count", sum(ar_hs) - ar0, (port < 0) ? 0 : 1);
        rd_port = -2;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [1:0] br, rr, br2;
        logic [31:0] rd;
        int t;
        for (int p = 0; p < NS; p++) begin
            aw_stall[p] = 0; b_dly[p] = 1; r_dly[p] = 1;
            awv_cyc[p] = 0; wv_cyc[p] = 0;
        end
        bresp_cfg[0] = 2'b00; bresp_cfg[1] = 2'b01;
        rresp_cfg[0] = 2'b00; rresp_cfg[1] = 2'b10;
        rdata_cfg[0] = 32'h0000_1234; rdata_cfg[1] = 32'hBEEF_0001;

        // reset and ready rise
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        #1 chk("ready_before_clk", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        @(negedge clk);
        chk("ready_after_clk", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

        // read to port 0
        do_read(32'h0200_BFF8, 0, rd, rr);
        chk("t1_rdata_lit", {rr, rd}, {2'b00, 32'h0000_1234});

        // write with W one cycle ahead of AW
        do_write(32'h0200_4000, 32'h0000_00A5, 1, 0, 0, br);
        chk("t2_bresp_lit", br, 2'b00);

        // AW ahead of W, with read back-pressure afterwards
        do_write(32'h0200_0100, 32'hCAFE_F00D, 0, 2, 0, br);
        chk("t2b_bresp_lit", br, 2'b00);
        do_read(32'h1000_0020, 3, rd, rr);
        chk("t2c_read_lit", {rr, rd}, {2'b10, 32'hBEEF_0001});

        // port-1 AW stalled 5 cycles, W accepted at once
        aw_stall[1] = 5; awv_cyc[1] = 0; wv_cyc[1] = 0;
        do_write(32'h1000_0004, 32'h1111_2222, 0, 0, 0, br);
        chk("t3_awvalid_cycles", awv_cyc[1], 6);
        chk("t3_wvalid_cycles", wv_cyc[1], 1);
        chk("t3_bresp_lit", br, 2'b01);
        aw_stall[1] = 0;

        // unmapped address
        do_write(32'h3000_0000, 32'h5555_AAAA, 0, 0, 0, br);
        do_read(32'h3000_0000, 0, rd, rr);
`ifdef AXIL_DEC_DECERR_EN
        chk("t4_bresp_lit", br, 2'b11);
        chk("t4_read_lit", {rr, rd}, {2'b11, 32'h0});
`else
        chk("t4_bresp_lit", br, 2'b01);
        chk("t4_read_lit", {rr, rd}, {2'b10, 32'hBEEF_0001});
`endif

        // B held off for 4 cycles while a read to port 1 completes
        fork
            do_write(32'h0200_0040, 32'h0BAD_BEEF, 0, 0, 4, br2);
            begin
                repeat (2) @(posedge clk);
                do_read(32'h1000_0010, 0, rd, rr);
            end
        join
        chk("t5_bresp_lit", br2, 2'b00);
        chk("t5_read_lit", {rr, rd}, {2'b10, 32'hBEEF_0001});

        // reset while waiting for B
        b_dly[0] = 40;
        wr_port = 0; wr_addr = 32'h0200_0010; wr_data = 32'h7777_7777; wr_strb = 4'hF;
        @(posedge clk);
        #1 s_axi_awaddr = wr_addr; s_axi_wdata = wr_data; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(negedge clk);
        chk("t6_accept", {s_axi_awready, s_axi_wready}, 2'b11);
        @(posedge clk); #1 s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        t = 0;
        while (!m_axi_bready[0] && t < 50) begin @(negedge clk); t++; end
        chk("t6_in_wresp", m_axi_bready[0], 1);
        #2 rst_n = 1'b0;
        #1 chk("t6_async_reset",
               {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
                s_axi_bresp, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 64'd0);
        wr_port = -2;
        b_dly[0] = 1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ready_rise", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
        do_write(32'h1000_0008, 32'h1234_5678, 0, 0, 0, br);
        chk("t6_post_reset_bresp_lit", br, 2'b01);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
